button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Upstream conditioning stage for the lab counter. It turns a raw, bouncing push-button or switch input into a clean debounced level plus single-cycle rise and fall pulses.
- The rise pulse drives the downstream counter's count enable, or its clock in the simple lab setup, so one press advances the count by exactly one.
- Contents: a 2-flop synchronizer followed by a 4-state stability FSM with a consecutive-sample counter.

Parameters:
- STABLE_CYCLES, default 4: number of consecutive identical synchronized samples required to accept a new level. Legal range 2..65535.
- INVERT, default 0: when 1, btn_in is treated as active-low and inverted before the synchronizer.

Ports:
- clock  input  1: single system clock; all state updates on its rising edge.
- reset  input  1: asynchronous, active-high reset.
- btn_in  input  1: raw asynchronous button or switch input.
- level  output  1: debounced level.
- rise  output  1: one-cycle pulse when level goes 0->1.
- fall  output  1: one-cycle pulse when level goes 1->0.

Behaviour:
- Reset: s1, s2, level, rise and fall are all 0; state is STABLE_LOW; cnt is 0.
  - Reset takes effect immediately, with no clock needed, including mid-debounce. Any pending transition is discarded.
- Synchronizer:
  - x = btn_in XOR INVERT.
  - Each rising edge: s1 <= x, then s2 <= s1.
  - The FSM reads only s2.
- Counter:
  - cnt width is clog2(STABLE_CYCLES + 1).
  - cnt saturates by construction because it is cleared on every state exit. It never wraps.
- States: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. All transitions happen on the rising clock edge.
- STABLE_LOW:
  - s2 = 0: stay.
  - s2 = 1: go to WAIT_HIGH with cnt <= 1.
- WAIT_HIGH:
  - s2 = 0: return to STABLE_LOW with cnt <= 0. This is a bounce and produces no pulse.
  - s2 = 1 and cnt = STABLE_CYCLES-1: go to STABLE_HIGH with level <= 1, rise <= 1, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
- STABLE_HIGH and WAIT_LOW mirror the above with polarity swapped. Reaching the threshold sets level <= 0 and fall <= 1.
- rise and fall are registered and high for exactly one cycle. They are never both high in the same cycle.
- level changes only in the cycle where rise or fall is asserted.
- Latency: if btn_in is captured at edge k and then held, level and the pulse become visible after edge k+1+STABLE_CYCLES. With the default of 4, that is edge k+5.
- Glitch rejection: any opposite-level s2 sample during a WAIT state restarts the count from the stable state.
  - A new transition needs a full fresh run of STABLE_CYCLES samples.
  - Pulses of STABLE_CYCLES-1 synchronized cycles or shorter never change level.
- btn_in high through reset release:
  - s2 = 1 by edge 2 after release.
  - level rises, and rise pulses, at edge 2+STABLE_CYCLES. This is legal and required.
- Toggling btn_in every cycle indefinitely never changes level and never produces pulses.

Test Plan:
- Reset, then btn_in = 0 held for 20 cycles (100 ns clock, STABLE_CYCLES = 4) -> level, rise and fall stay 0 throughout.
- btn_in 0->1 captured at edge k, then held -> level = 1 and rise = 1 exactly after edge k+5; rise = 0 after edge k+6; fall stays 0.
- Bounce: btn_in high for 2 cycles, low for 1 cycle, high for 2 cycles, then low -> level stays 0 and no pulses.
  - Then hold btn_in high for 4+ cycles -> a single rise.
- Release with bounce: from level = 1, btn_in toggles 1,0,1,0 over 4 cycles, then stays 0 -> exactly one fall, 5 edges after the last 1->0 capture; level = 0 afterwards.
- Chain check: button_debouncer.rise drives the enable of a 2-bit counter; apply 5 clean presses of 8 cycles high and 8 cycles low -> the counter reads 1,2,3,0,1 after the respective presses. Check each value at the negedge following its rise.
- Reset mid-debounce: assert reset when cnt = 2 in WAIT_HIGH -> level, rise and fall are 0 immediately.
  - After release with btn_in still 1 -> rise at edge 6 after release.
- INVERT = 1 instance: btn_in held 0 -> level = 1 after edge 6 from reset release, with rise asserted in that same cycle.

Source files
------------

// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchronizer feeding a 4-state stability FSM.
// Latency: a held input change shows on level/rise/fall STABLE_CYCLES+1 edges after capture.
// No backpressure: free-running, one synchronized sample consumed per clock.
module button_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int INVERT        = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic INV = (INVERT != 0);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  logic             x;
  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Active-low buttons are flipped before synchronizing so the FSM always sees active-high.
  assign x = btn_in ^ INV;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= x;
      s2 <= s1;
    end
  end

  // FSM state, sample counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Next-state logic: the first differing sample counts as one, so entering a WAIT
  // state loads cnt with 1 and the threshold is reached on the STABLE_CYCLES-th sample.
  // Any sample matching the current level abandons the pending transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: scoreboard of expected level/rise/fall per cycle,
// filled from a run-length reference model, plus directed reset, INVERT and
// counter-chain checks.
module tb_button_debouncer;

  localparam int S = 4;

  typedef struct packed {
    logic l;
    logic r;
    logic f;
  } exp_t;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic btn_in  = 1'b0;
  logic inv_btn = 1'b0;
  logic level, rise, fall;
  logic inv_level, inv_rise, inv_fall;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  exp_t q[$];

  // Reference model state: synchronizer pipeline, accepted level, run length of
  // consecutive synchronized samples that disagree with the accepted level.
  logic m_s1  = 1'b0;
  logic m_s2  = 1'b0;
  logic m_lvl = 1'b0;
  int   m_run = 0;

  always #50 clock = ~clock;

  button_debouncer #(.STABLE_CYCLES(S), .INVERT(0)) dut (
    .clock (clock),
    .reset (reset),
    .btn_in(btn_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  button_debouncer #(.STABLE_CYCLES(S), .INVERT(1)) dut_inv (
    .clock (clock),
    .reset (reset),
    .btn_in(inv_btn),
    .level (inv_level),
    .rise  (inv_rise),
    .fall  (inv_fall)
  );

  // Downstream 2-bit counter enabled by the debounced rise pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt2 <= 2'd0;
    else if (rise) cnt2 <= cnt2 + 2'd1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #5 btn_in = v;
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic smp;
    e = '0;
    if (reset) begin
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      m_lvl = 1'b0;
      m_run = 0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_in;
      if (smp != m_lvl) begin
        m_run++;
        if (m_run == S) begin
          m_lvl = ~m_lvl;
          if (m_lvl) e.r = 1'b1;
          else e.f = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      e.l = m_lvl;
    end
    q.push_back(e);
  endtask

  // Model: advance on every rising edge and push the expected post-edge outputs.
  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // Monitor: compare DUT outputs against the scoreboard away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("level", level, e.l);
        check("rise", rise, e.r);
        check("fall", fall, e.f);
      end
    end
  end

  // Active-low instance with input held low: must see level rise at edge 6 after release.
  initial begin
    @(negedge reset);
    for (int e = 1; e <= 7; e++) begin
      @(negedge clock);
      check("inv_level", inv_level, (e >= 6) ? 8'd1 : 8'd0);
      check("inv_rise", inv_rise, (e == 6) ? 8'd1 : 8'd0);
      check("inv_fall", inv_fall, 8'd0);
    end
  end

  initial begin
    logic [1:0] chain_exp [5];
    chain_exp[0] = 2'd1;
    chain_exp[1] = 2'd2;
    chain_exp[2] = 2'd3;
    chain_exp[3] = 2'd0;
    chain_exp[4] = 2'd1;

    repeat (3) @(negedge clock);
    #5 reset = 1'b0;

    // Idle, clean press and release.
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 10);

    // Short bounces never accepted, then a solid press.
    drive(1'b1, 2);
    drive(1'b0, 1);
    drive(1'b1, 2);
    drive(1'b0, 8);
    drive(1'b1, 8);

    // Release with bounce.
    drive(1'b1, 1);
    drive(1'b0, 1);
    drive(1'b1, 1);
    drive(1'b0, 10);

    // Toggle every cycle.
    for (int i = 0; i < 40; i++) drive(i % 2 == 0, 1);
    drive(1'b0, 6);

    // Random hold lengths around the threshold.
    repeat (60) drive(logic'($urandom_range(0, 1)), $urandom_range(1, 7));

    // Asynchronous reset while level is high clears outputs without a clock.
    drive(1'b1, 10);
    @(negedge clock);
    #5 reset = 1'b1;
    #1;
    check("rst_async_level", level, 8'd0);
    check("rst_async_rise", rise, 8'd0);
    check("rst_async_fall", fall, 8'd0);
    btn_in = 1'b0;
    @(negedge clock);
    #5 reset = 1'b0;
    drive(1'b0, 10);

    // Reset in WAIT_HIGH with cnt = 2, then release with the button still pressed.
    drive(1'b1, 4);
    @(negedge clock);
    #5 reset = 1'b1;
    #1;
    check("rst_mid_level", level, 8'd0);
    check("rst_mid_rise", rise, 8'd0);
    check("rst_mid_fall", fall, 8'd0);
    @(negedge clock);
    #5 reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clock);
      check("rst_mid_rise_edge", rise, (e == 6) ? 8'd1 : 8'd0);
    end
    drive(1'b1, 3);

    // Counter chain: five clean presses from a fresh reset.
    drive(1'b0, 10);
    @(negedge clock);
    #5 reset = 1'b1;
    @(negedge clock);
    #5 reset = 1'b0;
    for (int p = 0; p < 5; p++) begin
      drive(1'b1, 8);
      drive(1'b0, 8);
      check("chain_count", cnt2, chain_exp[p]);
    end

    drive(1'b0, 5);
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
